// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the seq_mult_arbiter slice:
//   state_t   - sequencer FSM encoding (IDLE/ISSUE/WAIT/RESP, 2 bits)
//   clog2     - ceiling log2 for elaboration-time sizing
//   id_width  - width of a requester index, never less than 1 bit
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A single requester still needs a 1-bit index field.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/seq_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// seq_mult_arbiter_if
// Bundles the requester channels and the shared-multiplier channels.
//   req_valid/req_ready/req_a/req_b  - per-requester request (operands packed)
//   rsp_valid/rsp_ready/rsp_p/rsp_id - per-requester response, shared data bus
//   mul_in_valid/ready, mul_a/mul_b  - operand handshake to the multiplier
//   mul_out_valid/ready, mul_p       - product handshake from the multiplier
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + multiplier)
// -----------------------------------------------------------------------------
interface seq_mult_arbiter_if
    import seq_mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 8
);
    localparam int P_W  = A_W + B_W;
    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*A_W-1:0]   req_a;
    logic [N_REQ*B_W-1:0]   req_b;

    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic signed [P_W-1:0]  rsp_p;
    logic [ID_W-1:0]        rsp_id;

    logic                   mul_in_valid;
    logic                   mul_in_ready;
    logic signed [A_W-1:0]  mul_a;
    logic signed [B_W-1:0]  mul_b;
    logic                   mul_out_valid;
    logic                   mul_out_ready;
    logic signed [P_W-1:0]  mul_p;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  mul_in_ready, mul_out_valid, mul_p,
        output req_ready, rsp_valid, rsp_p, rsp_id,
        output mul_in_valid, mul_a, mul_b, mul_out_ready
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output mul_in_ready, mul_out_valid, mul_p,
        input  req_ready, rsp_valid, rsp_p, rsp_id,
        input  mul_in_valid, mul_a, mul_b, mul_out_ready
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first asserted request bit
// starting at ptr and wrapping modulo N_REQ.
//   req       in  N_REQ  request vector
//   ptr       in  ID_W   highest-priority index
//   any_valid out 1      at least one request bit set
//   winner    out ID_W   selected index (0 when any_valid is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any_valid,
    output logic [ID_W-1:0]  winner
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest offset down to ptr itself so the closest
    // asserted request (in rotation order) is the last one written.
    always_comb begin
        any_valid = |req;
        winner    = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/seq_mult_arbiter.sv
// -----------------------------------------------------------------------------
// seq_mult_arbiter
// Round-robin arbiter/sequencer sharing one signed sequential multiplier among
// N_REQ requesters, one operation in flight at a time.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    if   seq_mult_arbiter_if.slave (request, response, multiplier)
//   busy   out  high whenever the sequencer is not IDLE
// Flow: IDLE (grant) -> ISSUE (mul_in handshake) -> WAIT (mul_out handshake)
//       -> RESP (requester response handshake) -> IDLE.
// Products are forwarded bit-exact from the multiplier.
// -----------------------------------------------------------------------------
module seq_mult_arbiter
    import seq_mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_mult_arbiter_if.slave bus,
    output logic              busy
);

    localparam int P_W  = A_W + B_W;
    localparam int ID_W = id_width(N_REQ);

    state_t                state, state_nxt;
    logic [ID_W-1:0]       rr_ptr, owner, winner, ptr_nxt;
    logic                  any_valid;

    logic signed [A_W-1:0] a_arr [N_REQ];
    logic signed [B_W-1:0] b_arr [N_REQ];

    logic                  mul_in_valid_q;
    logic signed [A_W-1:0] mul_a_q;
    logic signed [B_W-1:0] mul_b_q;
    logic [N_REQ-1:0]      rsp_valid_q;
    logic signed [P_W-1:0] rsp_p_q;
    logic [ID_W-1:0]       rsp_id_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*A_W +: A_W];
        assign b_arr[i] = bus.req_b[i*B_W +: B_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .any_valid (any_valid),
        .winner    (winner)
    );

    // Pointer moves just past the winner; wraps to 0 (always 0 for N_REQ=1).
    assign ptr_nxt = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.req_ready     = '0;
        bus.mul_out_ready = 1'b0;
        busy              = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Grant is combinational; gated by rst_n so nothing is offered
                // while reset is held.
                if (any_valid && rst_n) begin
                    bus.req_ready = N_REQ'(1) << winner;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mul_in_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                bus.mul_out_ready = 1'b1;
                if (bus.mul_out_valid) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready[owner]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            owner          <= '0;
            mul_in_valid_q <= 1'b0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            rsp_valid_q    <= '0;
            rsp_p_q        <= '0;
            rsp_id_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner          <= winner;
                        mul_a_q        <= a_arr[winner];
                        mul_b_q        <= b_arr[winner];
                        mul_in_valid_q <= 1'b1;
                        rr_ptr         <= ptr_nxt;
                    end
                end
                ST_ISSUE: begin
                    if (mul_in_valid_q && bus.mul_in_ready) mul_in_valid_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (bus.mul_out_valid) begin
                        rsp_p_q     <= bus.mul_p;
                        rsp_id_q    <= owner;
                        rsp_valid_q <= N_REQ'(1) << owner;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[owner]) rsp_valid_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mul_in_valid = mul_in_valid_q;
    assign bus.mul_a        = mul_a_q;
    assign bus.mul_b        = mul_b_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_p        = rsp_p_q;
    assign bus.rsp_id       = rsp_id_q;

endmodule
